pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects RAW data hazards at ID (no forwarding in datapath) and inserts bubbles.
- Flushes younger stages on a taken branch resolved in MEM.
- Freezes the whole pipeline while the MEM stage waits on a data-memory req/ack handshake; a sticky error state is entered on handshake timeout.

Parameters:
- MEM_TIMEOUT, 16, max wait cycles for i_dmem_ack before error (legal range 2..255)
- CNT_W, 8, width of internal wait counter; must hold MEM_TIMEOUT

Ports:
- i_clk  in  1  clock, rising edge
- i_resetn  in  1  synchronous active-low reset
- i_id_rs1  in  5  rs1 index of instruction in IF/ID
- i_id_rs2  in  5  rs2 index of instruction in IF/ID
- i_id_use_rs1  in  1  IF/ID instruction reads rs1
- i_id_use_rs2  in  1  IF/ID instruction reads rs2
- i_ex_rd  in  5  rd in ID/EX
- i_ex_reg_write  in  1  ID/EX writes rd
- i_mem_rd  in  5  rd in EX/MEM
- i_mem_reg_write  in  1  EX/MEM writes rd
- i_wb_rd  in  5  rd in MEM/WB
- i_wb_reg_write  in  1  MEM/WB writes rd
- i_mem_access  in  1  EX/MEM holds a load or store
- i_pc_src  in  1  taken branch/jump resolved in MEM
- i_dmem_ack  in  1  data memory completes access this cycle
- o_dmem_req  out  1  request to data memory
- o_pc_stall  out  1  hold PC
- o_ifid_stall  out  1  hold IF/ID
- o_idex_stall  out  1  hold ID/EX
- o_exmem_stall  out  1  hold EX/MEM
- o_ifid_flush  out  1  clear IF/ID to NOP
- o_idex_flush  out  1  load bubble into ID/EX
- o_exmem_flush  out  1  load bubble into EX/MEM
- o_memwb_flush  out  1  load bubble into MEM/WB
- o_pc_load  out  1  PC takes jump address
- o_mem_err  out  1  sticky handshake timeout flag

Behaviour:
- States: RUN, MEM_WAIT, ERR. The state register and wait counter are clocked; all stall/flush/req outputs are combinational from state and inputs (same-cycle effect).
- Reset (i_resetn=0 at edge) -> state RUN, counter 0, o_mem_err 0. While i_resetn is low, all four flushes = 1 and all stalls, o_dmem_req and o_pc_load = 0.
- Hazard (haz) = (use_rs1 && rs1!=0 && rs1 matches any writing rd in EX, MEM or WB) || the same condition for rs2. An rd of x0 never matches.
- Freeze (frz) = i_mem_access && !i_dmem_ack && state in {RUN, MEM_WAIT}.
- Output priority: ERR > frz > i_pc_src > haz.
  - ERR: all stalls = 1, all flushes = 0, req = 0, pc_load = 0; o_mem_err = 1. Exits only via reset.
  - frz: o_dmem_req = 1; pc/ifid/idex/exmem stalls = 1; o_memwb_flush = 1 so WB does not repeat the write.
  - i_pc_src: o_pc_load = 1; ifid, idex and exmem flushes = 1; no stalls.
  - haz: pc and ifid stalls = 1; o_idex_flush = 1.
- o_dmem_req = i_mem_access in RUN/MEM_WAIT, including the ack cycle.
- RUN -> MEM_WAIT when frz; counter <= 1. An ack in the same cycle as the request is zero-wait: no stall, state stays RUN.
- MEM_WAIT:
  - i_dmem_ack -> RUN, counter <= 0, no freeze in that cycle.
  - else if counter == MEM_TIMEOUT-1 -> ERR.
  - else counter increments.
- i_mem_access dropping in MEM_WAIT without ack (protocol error) -> RUN, counter 0.
- i_pc_src together with i_mem_access is illegal; freeze takes priority and pc_src is ignored.
- A hazard with an rd still in WB needs 1 extra cycle; the regfile does not write-through.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds outputs o_stall_cnt[31:0] (cycles with o_pc_stall=1 outside ERR) and o_flush_cnt[31:0] (cycles with o_pc_load=1). Both are saturating, reset to 0, and count at the clock edge.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold i_resetn=0 for 2 cycles with i_mem_access=1 -> all flushes 1, o_dmem_req 0, o_mem_err 0; after release, state RUN.
- RAW: ID rs1=5 (used), EX rd=5 with reg_write -> pc/ifid stall and idex_flush for 3 consecutive cycles as the writer moves EX, MEM, WB. Same with rd=0 -> no stall.
- Branch: i_pc_src=1 for 1 cycle with a simultaneous hazard -> pc_load=1 and ifid/idex/exmem flush=1, no stalls.
- Memory wait: i_mem_access=1, ack after 3 cycles -> req high 4 cycles, pipeline stalls plus memwb_flush for 3 cycles, release on the ack cycle. Zero-wait ack -> no stall.
- Timeout: MEM_TIMEOUT=16, no ack -> ERR entered after cycle 16, o_mem_err=1, all stalls held. Only reset clears it.
- HAZ_PERF_CNT_EN: 3-cycle memory wait plus 2 branches -> o_stall_cnt=3, o_flush_cnt=2.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: RAW bubbles, branch flush, dmem freeze with timeout.
// Optional performance counters are enabled with HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_reg_write,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_reg_write,
  input  logic       i_mem_access,
  input  logic       i_pc_src,
  input  logic       i_dmem_ack,
  output logic       o_dmem_req,
  output logic       o_pc_stall,
  output logic       o_ifid_stall,
  output logic       o_idex_stall,
  output logic       o_exmem_stall,
  output logic       o_ifid_flush,
  output logic       o_idex_flush,
  output logic       o_exmem_flush,
  output logic       o_memwb_flush,
  output logic       o_pc_load,
  output logic       o_mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             haz_s, frz_s, active_s;

  // x0 is hardwired zero, so a write to it never creates a dependency.
  function automatic logic rd_hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return we && (rd == rs) && (rs != 5'd0);
  endfunction

  assign active_s = (state_q != ST_ERR);
  assign frz_s    = i_mem_access && !i_dmem_ack && active_s;
  assign haz_s    = (i_id_use_rs1 && (rd_hit(i_id_rs1, i_ex_rd, i_ex_reg_write) ||
                                      rd_hit(i_id_rs1, i_mem_rd, i_mem_reg_write) ||
                                      rd_hit(i_id_rs1, i_wb_rd, i_wb_reg_write))) ||
                    (i_id_use_rs2 && (rd_hit(i_id_rs2, i_ex_rd, i_ex_reg_write) ||
                                      rd_hit(i_id_rs2, i_mem_rd, i_mem_reg_write) ||
                                      rd_hit(i_id_rs2, i_wb_rd, i_wb_reg_write)));

  // Next state and wait counter; a dropped request in MEM_WAIT returns to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (frz_s) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (i_dmem_ack || !i_mem_access) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Same-cycle stall/flush decode, priority ERR > freeze > branch > hazard.
  always_comb begin
    o_dmem_req    = 1'b0;
    o_pc_stall    = 1'b0;
    o_ifid_stall  = 1'b0;
    o_idex_stall  = 1'b0;
    o_exmem_stall = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    o_memwb_flush = 1'b0;
    o_pc_load     = 1'b0;
    o_mem_err     = 1'b0;
    if (!i_resetn) begin
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
      o_memwb_flush = 1'b1;
    end else if (!active_s) begin
      o_pc_stall    = 1'b1;
      o_ifid_stall  = 1'b1;
      o_idex_stall  = 1'b1;
      o_exmem_stall = 1'b1;
      o_mem_err     = 1'b1;
    end else begin
      o_dmem_req = i_mem_access;
      if (frz_s) begin
        o_pc_stall    = 1'b1;
        o_ifid_stall  = 1'b1;
        o_idex_stall  = 1'b1;
        o_exmem_stall = 1'b1;
        o_memwb_flush = 1'b1;
      end else if (i_pc_src) begin
        o_pc_load     = 1'b1;
        o_ifid_flush  = 1'b1;
        o_idex_flush  = 1'b1;
        o_exmem_flush = 1'b1;
      end else if (haz_s) begin
        o_pc_stall    = 1'b1;
        o_ifid_stall  = 1'b1;
        o_idex_flush  = 1'b1;
      end else begin
        o_pc_stall    = 1'b0;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters for stall and redirect cycles.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (o_pc_stall && active_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (o_pc_load && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule
